// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier: one partial product per clock, WIDTH x WIDTH -> 2*WIDTH,
// unsigned or two's-complement per operation, start/done handshake with back-to-back issue.
module seq_shift_add_multiplier #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        counter_q, counter_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   partial, acc_sum;

  // Operands are reduced to magnitudes; the sign is reapplied once to the final sum.
  // Multiplicand shifts left and multiplier shifts right, so bit i of mag_b meets mag_a << i.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    counter_d = counter_q;
    product_d = product_q;

    mag_a   = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b   = (is_signed && b[WIDTH-1]) ? -b : b;
    partial = mplier_q[0] ? mcand_q : '0;
    acc_sum = acc_q + partial;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          mcand_d   = {{WIDTH{1'b0}}, mag_a};
          mplier_d  = mag_b;
          neg_d     = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d     = '0;
          counter_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d     = acc_sum;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        counter_d = counter_q + CW'(1);
        if (counter_q == LAST) begin
          state_d   = DONE;
          product_d = neg_q ? -acc_sum : acc_sum;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      counter_q <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      counter_q <= counter_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: 16-bit instance for directed/random/handshake cases,
// 4-bit instance for the exhaustive sweep; reference products come from plain integer arithmetic.
module tb_seq_shift_add_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start16, sgn16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] prod16;
  logic        start4, sgn4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  prod4;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  seq_shift_add_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .is_signed(sgn16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .product(prod16)
  );

  seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .is_signed(sgn4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  function automatic logic [31:0] model16(input logic [15:0] x, input logic [15:0] y, input logic s);
    longint px, py, pr;
    px = (s && x[15]) ? longint'(x) - 65536 : longint'(x);
    py = (s && y[15]) ? longint'(y) - 65536 : longint'(y);
    pr = px * py;
    return pr[31:0];
  endfunction

  function automatic logic [7:0] model4(input logic [3:0] x, input logic [3:0] y, input logic s);
    int px, py, pr;
    px = (s && x[3]) ? int'(x) - 16 : int'(x);
    py = (s && y[3]) ? int'(y) - 16 : int'(y);
    pr = px * py;
    return pr[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op; lat is the number of edges after the accept edge until done is seen.
  task automatic run16(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                       output logic [31:0] p, output int lat);
    start16 = 1'b1; a16 = ta; b16 = tb_; sgn16 = ts;
    tick();
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = 1'($urandom);
    vectors++;
    if (busy16 !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_accept: got %b expected 1", busy16);
    end
    lat = 0;
    while (lat < 40) begin
      tick();
      lat++;
      if (done16 === 1'b1) break;
    end
    p = prod16;
  endtask

  task automatic run4(input logic [3:0] ta, input logic [3:0] tb_, input logic ts,
                      output logic [7:0] p, output int lat);
    start4 = 1'b1; a4 = ta; b4 = tb_; sgn4 = ts;
    tick();
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sgn4 = 1'($urandom);
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (done4 === 1'b1) break;
    end
    p = prod4;
  endtask

  task automatic check_op16(input string name, input logic [15:0] x, input logic [15:0] y,
                            input logic s);
    logic [31:0] p, exp;
    int lat;
    exp = model16(x, y, s);
    run16(x, y, s, p, lat);
    vectors++;
    if (p !== exp) begin
      miscompares++;
      $display("FAIL %s: a=%h b=%h signed=%b product got %h expected %h", name, x, y, s, p, exp);
    end
    vectors++;
    if (lat != 16) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d edges expected 16", name, lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;
    start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    vectors++;
    if ({busy16, done16, prod16} !== 34'h0) begin
      miscompares++;
      $display("FAIL reset16: busy=%b done=%b product=%h expected 0 0 0", busy16, done16, prod16);
    end
    vectors++;
    if ({busy4, done4, prod4} !== 10'h0) begin
      miscompares++;
      $display("FAIL reset4: busy=%b done=%b product=%h expected 0 0 0", busy4, done4, prod4);
    end
  endtask

  task automatic test_directed();
    check_op16("unsigned_max", 16'hFFFF, 16'hFFFF, 1'b0);
    check_op16("signed_3x-5", 16'h0003, 16'hFFFB, 1'b1);
    check_op16("signed_-1x-1", 16'hFFFF, 16'hFFFF, 1'b1);
    check_op16("signed_min_sq", 16'h8000, 16'h8000, 1'b1);
    check_op16("unsigned_8000_sq", 16'h8000, 16'h8000, 1'b0);
    check_op16("signed_min_x1", 16'h8000, 16'h0001, 1'b1);
    check_op16("zero_operand", 16'h0000, 16'h1234, 1'b1);
  endtask

  task automatic test_random16();
    for (int i = 0; i < 12; i++)
      check_op16("random16", 16'($urandom), 16'($urandom), 1'(i % 2));
  endtask

  task automatic test_back_to_back();
    logic [15:0] x1, y1, x2, y2;
    logic s1, s2;
    logic [31:0] p1;
    int lat, k;
    x1 = 16'($urandom); y1 = 16'($urandom); s1 = 1'b1;
    x2 = 16'($urandom); y2 = 16'($urandom); s2 = 1'b0;
    start16 = 1'b1; a16 = x1; b16 = y1; sgn16 = s1;
    tick();
    lat = 0;
    while (lat < 40) begin
      a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = 1'($urandom);
      tick();
      lat++;
      if (done16 === 1'b1) break;
    end
    p1 = prod16;
    vectors++;
    if (lat != 16) begin
      miscompares++;
      $display("FAIL held_start_latency: got %0d expected 16", lat);
    end
    vectors++;
    if (p1 !== model16(x1, y1, s1)) begin
      miscompares++;
      $display("FAIL held_start_product: got %h expected %h", p1, model16(x1, y1, s1));
    end
    // start still high in the DONE cycle: the second op is accepted on the next edge
    a16 = x2; b16 = y2; sgn16 = s2;
    k = 0;
    while (k < 40) begin
      tick();
      k++;
      if (done16 === 1'b1) break;
      a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = 1'($urandom);
      if (k == 8) begin
        vectors++;
        if (prod16 !== p1) begin
          miscompares++;
          $display("FAIL product_hold: got %h expected %h", prod16, p1);
        end
      end
    end
    vectors++;
    if (k != 17) begin
      miscompares++;
      $display("FAIL done_spacing: got %0d cycles expected 17", k);
    end
    vectors++;
    if (prod16 !== model16(x2, y2, s2)) begin
      miscompares++;
      $display("FAIL back_to_back_product: got %h expected %h", prod16, model16(x2, y2, s2));
    end
    start16 = 1'b0;
    tick();
    vectors++;
    if (busy16 !== 1'b0 || done16 !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_release: busy=%b done=%b expected 0 0", busy16, done16);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    start16 = 1'b1; a16 = 16'h1234; b16 = 16'h5678; sgn16 = 1'b0;
    tick();
    start16 = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({busy16, done16, prod16} !== 34'h0) begin
      miscompares++;
      $display("FAIL mid_run_reset: busy=%b done=%b product=%h expected 0 0 0",
               busy16, done16, prod16);
    end
    seen = 0;
    repeat (20) begin
      tick();
      if (done16 === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL aborted_done: got %0d done pulses expected 0", seen);
    end
    check_op16("after_reset", 16'hBEEF, 16'h0F0F, 1'b1);
  endtask

  task automatic test_w4_exhaustive();
    logic [7:0] p, exp;
    int lat;
    logic [3:0] x, y;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          x = 4'(i); y = 4'(j);
          repeat ($urandom_range(0, 3)) tick();
          exp = model4(x, y, 1'(s));
          run4(x, y, 1'(s), p, lat);
          vectors++;
          if (p !== exp || lat != 4) begin
            miscompares++;
            $display("FAIL w4: a=%h b=%h signed=%0d product got %h lat %0d expected %h lat 4",
                     x, y, s, p, lat, exp);
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_random16();
    test_back_to_back();
    test_reset_mid_run();
    test_w4_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
